// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, types and helpers for the 7-segment scan controller
// Contents: NDIG digit count, BCD nibble type, segment patterns (a..g, seg[0]=a),
//           bcd_valid() range check.
package seg7_pkg;

  localparam int NDIG = 6;

  typedef logic [3:0] bcd_t;

  // Segment patterns, index 0 is segment a, index 6 is segment g, active-high.
  localparam logic [0:6] SEG_0   = 7'b1111110;
  localparam logic [0:6] SEG_1   = 7'b0110000;
  localparam logic [0:6] SEG_2   = 7'b1101101;
  localparam logic [0:6] SEG_3   = 7'b1111001;
  localparam logic [0:6] SEG_4   = 7'b0110011;
  localparam logic [0:6] SEG_5   = 7'b1011011;
  localparam logic [0:6] SEG_6   = 7'b1011111;
  localparam logic [0:6] SEG_7   = 7'b1110000;
  localparam logic [0:6] SEG_8   = 7'b1111111;
  localparam logic [0:6] SEG_9   = 7'b1111011;
  localparam logic [0:6] SEG_OFF = 7'b0000000;

  function automatic logic bcd_valid(input bcd_t d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD to 7-segment decoder
// Ports:
//   digit  in   4      BCD nibble
//   seg    out  [0:6]  segments a..g, active-high; values above 9 decode dark
module seg7_decode
  import seg7_pkg::*;
(
  input  bcd_t       digit,
  output logic [0:6] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - six-digit multiplexed 7-segment scan scheduler
// Ports:
//   clk         in   1      system clock, rising edge
//   clr         in   1      asynchronous active-high reset
//   digits_in   in   24     six BCD nibbles, [3:0]=digit 0 (sec ones) .. [23:20]=digit 5
//   blank_mask  in   6      bit i forces digit i dark
//   blink_mask  in   6      bit i makes digit i blink
//   load        in   1      request capture of digits/masks at the next frame boundary
//   seg         out  [0:6]  segments a..g, active-high, registered
//   dig_sel     out  6      one-hot digit enable, registered
//   frame_done  out  1      one-cycle pulse after the last cycle of each frame
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [23:0]     digits_in,
  input  logic [NDIG-1:0] blank_mask,
  input  logic [NDIG-1:0] blink_mask,
  input  logic            load,
  output logic [0:6]      seg,
  output logic [NDIG-1:0] dig_sel,
  output logic            frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [2:0] LAST_SLOT = 3'(NDIG - 1);

  logic [CW-1:0]         cnt;
  logic [2:0]            slot;
  logic [FW-1:0]         frame_cnt;
  logic                  blink_phase;
  logic                  pending;
  bcd_t [NDIG-1:0]       snap_digits;
  logic [NDIG-1:0]       snap_blank;
  logic [NDIG-1:0]       snap_blink;

  logic                  cnt_wrap;
  logic                  boundary;
  logic                  frame_wrap;
  logic                  in_guard;
  logic                  dark;
  bcd_t                  cur_digit;
  logic [0:6]            dec_seg;

  assign cnt_wrap   = (cnt == CW'(SCAN_DIV - 1));
  assign boundary   = cnt_wrap && (slot == LAST_SLOT);
  assign frame_wrap = (frame_cnt == FW'(BLINK_FRAMES - 1));
  assign in_guard   = (cnt < CW'(GUARD));
  assign cur_digit  = snap_digits[slot];

  // Any one of blanking, the off half of a blink, or a non-BCD nibble darkens the slot.
  assign dark = snap_blank[slot] | (snap_blink[slot] & blink_phase) | !bcd_valid(cur_digit);

  seg7_decode u_decode (
    .digit (cur_digit),
    .seg   (dec_seg)
  );

  // Prescaler and slot sequencing.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt  <= '0;
      slot <= '0;
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + CW'(1);
      if (cnt_wrap)
        slot <= (slot == LAST_SLOT) ? 3'd0 : slot + 3'd1;
    end
  end

  // Frame counter and blink phase advance once per full frame.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (boundary) begin
        frame_cnt <= frame_wrap ? '0 : frame_cnt + FW'(1);
        if (frame_wrap)
          blink_phase <= ~blink_phase;
      end
    end
  end

  // Snapshot only changes at a frame boundary so a frame never mixes old and new digits.
  // A load seen mid-frame is remembered in pending; the values captured are the ones
  // present in the boundary cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pending     <= 1'b0;
      snap_digits <= '0;
      snap_blank  <= '1;
      snap_blink  <= '0;
    end else if (boundary) begin
      pending <= 1'b0;
      if (pending || load) begin
        snap_digits <= digits_in;
        snap_blank  <= blank_mask;
        snap_blink  <= blink_mask;
      end
    end else if (load) begin
      pending <= 1'b1;
    end
  end

  // Output registers; the guard window at each slot start keeps all digits off so the
  // previous digit's segments do not ghost onto the next one.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      dig_sel <= '0;
      seg     <= SEG_OFF;
    end else if (in_guard) begin
      dig_sel <= '0;
      seg     <= SEG_OFF;
    end else begin
      dig_sel <= NDIG'(1) << slot;
      seg     <= dark ? SEG_OFF : dec_seg;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - scoreboard testbench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

  localparam int SCAN_DIV     = 4;
  localparam int GUARD        = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = 6 * SCAN_DIV;

  localparam logic [6:0] S2   = 7'b1101101;
  localparam logic [6:0] S3   = 7'b1111001;
  localparam logic [6:0] S4   = 7'b0110011;
  localparam logic [6:0] S5   = 7'b1011011;
  localparam logic [6:0] S6   = 7'b1011111;
  localparam logic [6:0] S9   = 7'b1111011;
  localparam logic [6:0] SOFF = 7'b0000000;

  // Frame images, slot 5 leftmost ... slot 0 rightmost.
  localparam logic [41:0] F_DARK   = {SOFF, SOFF, SOFF, SOFF, SOFF, SOFF};
  localparam logic [41:0] F_235959 = {S2, S3, S5, S9, S5, S9};
  localparam logic [41:0] F_2359A9 = {S2, S3, S5, S9, SOFF, S9};
  localparam logic [41:0] F_BLINK  = {S2, S3, S5, S9, SOFF, SOFF};
  localparam logic [41:0] F_123456 = {SOFF, S2, S3, S4, S5, S6};

  typedef struct packed {
    logic [5:0] sel;
    logic [6:0] seg;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [23:0] digits_in = '0;
  logic [5:0]  blank_mask = '0;
  logic [5:0]  blink_mask = '0;
  logic        load = 1'b0;
  logic [0:6]  seg;
  logic [5:0]  dig_sel;
  logic        frame_done;

  int   n_checks = 0;
  int   n_fail = 0;
  int   ecount = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .SCAN_DIV     (SCAN_DIV),
    .GUARD        (GUARD),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .digits_in  (digits_in),
    .blank_mask (blank_mask),
    .blink_mask (blink_mask),
    .load       (load),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .frame_done (frame_done)
  );

  // Rising edges since reset release.
  always @(posedge clk or posedge clr) begin
    if (clr) ecount <= 0;
    else     ecount <= ecount + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t edge=%0d)", name, act, exp, $time, ecount);
    end
  endtask

  task automatic push_frame(input logic [41:0] v, input int nslots);
    exp_t e;
    for (int s = 0; s < nslots; s++) begin
      e.sel = 6'(1 << s);
      e.seg = v[s*7 +: 7];
      repeat (SCAN_DIV - GUARD) q.push_back(e);
    end
  endtask

  task automatic to_edge(input int e);
    while (ecount < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [23:0] d, input logic [5:0] bl, input logic [5:0] bk);
    digits_in  = d;
    blank_mask = bl;
    blink_mask = bk;
    load       = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Monitor: every lit cycle consumes one scoreboard entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic lit;
    if (clr) begin
      check("reset_dig_sel", 32'(dig_sel), 0);
      check("reset_seg", 32'(seg), 0);
      check("reset_frame_done", 32'(frame_done), 0);
    end else begin
      check("frame_done", 32'(frame_done), 32'(ecount > 0 && ecount % FRAME == 0));
      lit = (ecount >= 1) && (ecount % SCAN_DIV != 1);
      if (!lit) begin
        check("guard_dig_sel", 32'(dig_sel), 0);
        check("guard_seg", 32'(seg), 0);
      end else if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underrun: got dig_sel=%0h seg=%0h with no expected entry", dig_sel, seg);
      end else begin
        e = q.pop_front();
        check("dig_sel", 32'(dig_sel), 32'(e.sel));
        check("seg", 32'(seg), 32'(e.seg));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    n_fail++;
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b0;

    // Frames 0 and 1 dark; load issued mid-frame 1 shows from frame 2.
    push_frame(F_DARK, 6);
    push_frame(F_DARK, 6);
    to_edge(33);
    push_frame(F_235959, 6);
    do_load(24'h235959, 6'b000000, 6'b000000);

    // Invalid nibble in digit 1.
    to_edge(57);
    push_frame(F_2359A9, 6);
    do_load(24'h2359A9, 6'b000000, 6'b000000);

    // Blink digits 0-1: phase 0 on frames 4,5 and 8,9; phase 1 on frames 6,7.
    to_edge(81);
    push_frame(F_235959, 6);
    push_frame(F_235959, 6);
    push_frame(F_BLINK, 6);
    push_frame(F_BLINK, 6);
    push_frame(F_235959, 6);
    push_frame(F_235959, 6);
    do_load(24'h235959, 6'b000000, 6'b000011);

    // Load exactly in the boundary cycle (cnt=3, slot=5) of frame 9, blanking digit 5.
    to_edge(239);
    check("pending_before_boundary", 32'(dut.pending), 0);
    push_frame(F_123456, 6);
    push_frame(F_123456, 3);
    do_load(24'h123456, 6'b100000, 6'b000000);
    check("pending_after_boundary", 32'(dut.pending), 0);

    // Asynchronous reset between edges while slot 3 of frame 11 is lit.
    to_edge(278);
    #1;
    clr = 1'b1;
    #1;
    check("async_clr_dig_sel", 32'(dig_sel), 0);
    check("async_clr_seg", 32'(seg), 0);
    check("async_clr_frame_done", 32'(frame_done), 0);
    check("scoreboard_drained_at_clr", 32'(q.size()), 0);

    // After release the snapshot is blanked, so two full frames stay dark.
    push_frame(F_DARK, 6);
    push_frame(F_DARK, 6);
    @(posedge clk);
    @(posedge clk);
    #1;
    clr = 1'b0;
    to_edge(50);
    check("scoreboard_drained_end", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Display scan scheduler for the six-digit HH:MM:SS clock. It time-multiplexes six BCD digits from the timekeeping counters onto one shared 7-segment bus and a one-hot digit select. Digit updates are captured tear-free at frame boundaries. Per-digit blanking and blinking support set-mode, and an anti-ghosting guard interval separates slots. It sits between the sec/min/hour counters and the board's segment/digit pins.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot (>= GUARD+1, >= 2)
GUARD, 16, cycles at the start of each slot with all digits off (0 <= GUARD < SCAN_DIV)
BLINK_FRAMES, 64, complete 6-digit frames per blink half-period (>= 1)

Ports:
clk  in  1  system clock, all logic on rising edge
clr  in  1  reset, asynchronous, active-high
digits_in  in  24  six BCD nibbles; [3:0]=sec ones, [7:4]=sec tens, [11:8]=min ones, [15:12]=min tens, [19:16]=hour ones, [23:20]=hour tens
blank_mask  in  6  bit i=1 forces digit i dark
blink_mask  in  6  bit i=1 makes digit i blink
load  in  1  request capture of digits_in/blank_mask/blink_mask
seg  out  7 ([0:6])  segments a..g, active-high, seg[0]=a
dig_sel  out  6  one-hot digit enable, active-high, bit i = digit i
frame_done  out  1  one-cycle pulse at end of each frame

Behaviour:
- Reset (clr=1, async): prescaler=0, slot=0, frame count=0, blink_phase=0, pending=0, seg=0, dig_sel=0, frame_done=0, snapshot digits=0, snapshot blank=6'h3F, snapshot blink=0. The display stays dark until the first capture.
- Prescaler cnt counts 0..SCAN_DIV-1 and wraps. At cnt=SCAN_DIV-1, slot advances 0->1->...->5->0.
- Frame boundary is the cycle with cnt=SCAN_DIV-1 and slot=5. In that cycle:
  - frame_done=1 on the next edge, for exactly one cycle.
  - Frame count increments. At BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - If pending=1 or load=1, the snapshot takes the current-cycle digits_in/blank_mask/blink_mask and pending clears.
- Load outside a boundary sets pending=1. The snapshot holds until the next boundary. Multiple loads before a boundary keep only the boundary-cycle input values.
- Output (registered, 1-cycle latency from cnt/slot):
  - If cnt < GUARD: dig_sel=0, seg=0.
  - Otherwise dig_sel = 1<<slot, and seg = decode(snapshot digit[slot]).
  - seg is forced to 0 if blank[slot]=1, if (blink[slot]=1 and blink_phase=1), or if the nibble > 9.
- Decode a..g: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, else 0000000.
- dig_sel is never multi-hot. At most one bit is high in any cycle.
- clr mid-frame forces all reset values immediately. After release, scanning restarts at slot 0, cnt 0.
- Counter widths: $clog2 of each limit. No width truncation of BLINK_FRAMES or SCAN_DIV.

Decomposition:
- Package seg7_pkg:
  - NDIG=6
  - SEG_0..SEG_9 and SEG_OFF 7-bit constants
  - BCD nibble typedef
  - function bcd_valid
- Sub-module seg7_decode: combinational BCD->segment using the package constants. It is instantiated once on the selected snapshot nibble.
- Prescaler, slot counter, blink divider, snapshot and output registers stay in seg7_scan_ctrl.

Test Plan:
(Run with SCAN_DIV=4, GUARD=1, BLINK_FRAMES=2.)
1. Reset and no load: clr pulse -> seg=0, dig_sel=0 during reset. After release, dig_sel walks 000001..100000 (each high for cycles 1-3 of its slot), seg stays 0 throughout, frame_done pulses every 24 cycles.
2. Tear-free load: load digits_in=24'h235959, blank=0, blink=0 in slot 2 -> the remainder of the frame stays dark. Next frame shows:
   - slot0 seg=1111011 (9)
   - slot1 seg=1011011 (5)
   - slot4 seg=1111001 (3)
   - slot5 seg=1101101 (2)
3. Invalid BCD: digits_in=24'h2359A9 loaded -> slot1 seg=0000000, other slots decode normally.
4. Blink: blink_mask=6'b000011 loaded -> digits 0-1 visible on frames 0-1, dark on frames 2-3, visible on 4-5. Digits 2-5 are always visible.
5. Boundary load: load=1 exactly at cnt=3, slot=5 with new digits -> the very next frame shows the new values and pending stays 0.
6. Async reset mid-slot 3: clr rises between edges -> seg=0 and dig_sel=0 immediately. After release, scanning restarts at slot 0, dark until a new load.
